// File: rtl/pll_i2c_config.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pll_i2c_config
// Brief  : Write-only I2C master that streams a register table into a PLL
//          chip, one START/addr/reg/value/STOP transaction per entry.
// Rev    : 1.0  initial release
// ============================================================================
module pll_i2c_config #(
    parameter int         QUARTER_CYCLES = 120,
    parameter logic [6:0] DEV_ADDR       = 7'h60,
    parameter int         NUM_REGS       = 16,
    parameter int         AUTO_START     = 1
) (
    input  logic        clk_in,
    input  logic        nreset_in,
    input  logic        start,
    output logic [7:0]  rom_index,
    input  logic [15:0] rom_data,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int            TW        = (QUARTER_CYCLES > 2) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(QUARTER_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b0};
    localparam logic          AUTO_BIT  = (AUTO_START != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BYTE   = 3'd2,
        S_ACK    = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t        r_state, w_state_nx;
    logic [1:0]    r_quarter, w_quarter_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [1:0]    r_byte_sel, w_byte_sel_nx;
    logic [TW-1:0] r_tick_cnt, w_tick_cnt_nx;
    logic [15:0]   r_entry, w_entry_nx;
    logic          r_auto_pend, w_auto_pend_nx;
    logic [7:0]    w_index_nx;
    logic          w_busy_nx, w_done_nx, w_error_nx;
    logic          w_scl_nx, w_sda_nx;
    logic          w_tick;
    logic [7:0]    w_byte;

    assign w_tick = busy && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            r_state     <= S_IDLE;
            r_quarter   <= 2'd0;
            r_bit       <= 3'd0;
            r_byte_sel  <= 2'd0;
            r_tick_cnt  <= '0;
            r_entry     <= 16'd0;
            r_auto_pend <= AUTO_BIT;
            rom_index   <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_quarter   <= w_quarter_nx;
            r_bit       <= w_bit_nx;
            r_byte_sel  <= w_byte_sel_nx;
            r_tick_cnt  <= w_tick_cnt_nx;
            r_entry     <= w_entry_nx;
            r_auto_pend <= w_auto_pend_nx;
            rom_index   <= w_index_nx;
            busy        <= w_busy_nx;
            done        <= w_done_nx;
            error       <= w_error_nx;
            scl_oe      <= w_scl_nx;
            sda_oe      <= w_sda_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_quarter_nx   = r_quarter;
        w_bit_nx       = r_bit;
        w_byte_sel_nx  = r_byte_sel;
        w_auto_pend_nx = r_auto_pend;
        w_index_nx     = rom_index;
        w_busy_nx      = busy;
        w_done_nx      = done;
        w_error_nx     = error;
        w_tick_cnt_nx  = busy ? (w_tick ? '0 : r_tick_cnt + 1'b1) : '0;
        // The tick counter is zero exactly on the first cycle of START, by
        // which time rom_index already points at the new entry.
        w_entry_nx     = (r_state == S_START && r_quarter == 2'd0 && r_tick_cnt == '0)
                         ? rom_data : r_entry;

        case (r_state)
            S_IDLE: begin
                if (start || r_auto_pend) begin
                    w_state_nx     = S_START;
                    w_quarter_nx   = 2'd0;
                    w_busy_nx      = 1'b1;
                    w_done_nx      = 1'b0;
                    w_error_nx     = 1'b0;
                    w_index_nx     = 8'd0;
                    w_auto_pend_nx = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_quarter == 2'd0) begin
                        w_quarter_nx = 2'd1;
                    end else begin
                        w_state_nx    = S_BYTE;
                        w_quarter_nx  = 2'd0;
                        w_bit_nx      = 3'd7;
                        w_byte_sel_nx = 2'd0;
                    end
                end
            end
            S_BYTE: begin
                if (w_tick) begin
                    w_quarter_nx = r_quarter + 2'd1;
                    if (r_quarter == 2'd3) begin
                        if (r_bit == 3'd0) begin
                            w_state_nx = S_ACK;
                        end else begin
                            w_bit_nx = r_bit - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_tick) begin
                    w_quarter_nx = r_quarter + 2'd1;
                    if (r_quarter == 2'd2 && sda_in) begin
                        w_error_nx = 1'b1;
                    end
                    if (r_quarter == 2'd3) begin
                        if (error || r_byte_sel == 2'd2) begin
                            w_state_nx = S_STOP;
                        end else begin
                            w_state_nx    = S_BYTE;
                            w_bit_nx      = 3'd7;
                            w_byte_sel_nx = r_byte_sel + 2'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_quarter != 2'd2) begin
                        w_quarter_nx = r_quarter + 2'd1;
                    end else begin
                        w_quarter_nx = 2'd0;
                        if (error) begin
                            w_state_nx = S_FINISH;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b0;
                        end else begin
                            w_state_nx = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_quarter_nx = r_quarter + 2'd1;
                    if (r_quarter == 2'd3) begin
                        if (rom_index == LAST_IDX) begin
                            w_state_nx = S_FINISH;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = ~error;
                        end else begin
                            w_state_nx = S_START;
                            w_index_nx = rom_index + 8'd1;
                        end
                    end
                end
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        case (w_byte_sel_nx)
            2'd0:    w_byte = ADDR_BYTE;
            2'd1:    w_byte = w_entry_nx[15:8];
            default: w_byte = w_entry_nx[7:0];
        endcase

        // Line levels for the quarter being entered, registered so the pads
        // only ever move on a clock edge.
        w_scl_nx = 1'b0;
        w_sda_nx = 1'b0;
        case (w_state_nx)
            S_START: begin
                w_sda_nx = (w_quarter_nx == 2'd1);
            end
            S_BYTE: begin
                w_scl_nx = (w_quarter_nx == 2'd0) || (w_quarter_nx == 2'd3);
                w_sda_nx = ~w_byte[w_bit_nx];
            end
            S_ACK: begin
                w_scl_nx = (w_quarter_nx == 2'd0) || (w_quarter_nx == 2'd3);
            end
            S_STOP: begin
                w_scl_nx = (w_quarter_nx == 2'd0);
                w_sda_nx = (w_quarter_nx != 2'd2);
            end
            default: begin
                w_scl_nx = 1'b0;
                w_sda_nx = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/pll_i2c_config.md
PLL_I2C_CONFIG -- requirements
Module: pll_i2c_config

Interface
REQ-001 SHALL have parameter QUARTER_CYCLES, default 120, giving clk_in cycles per quarter SCL period (48 MHz / 400 k = 100 kHz SCL); minimum legal value 2.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h60, giving the 7-bit I2C address of the PLL chip.
REQ-003 SHALL have parameter NUM_REGS, default 16, giving the number of configuration table entries (1..256).
REQ-004 SHALL have parameter AUTO_START, default 1; when 1, one configuration pass starts automatically after reset release.
REQ-005 clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-006 nreset_in  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  single-cycle request for a configuration pass.
REQ-008 rom_index  output  8  table entry currently addressed.
REQ-009 rom_data  input  16  table entry, {reg_addr[15:8], reg_value[7:0]}; valid combinationally from rom_index.
REQ-010 scl_oe  output  1  1 = pull SCL low, 0 = release; the top level drives the pad to 1'bz when released.
REQ-011 sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-012 sda_in  input  1  sampled SDA pad level.
REQ-013 busy  output  1  high while a pass is in progress.
REQ-014 done  output  1  sticky; all NUM_REGS writes were acknowledged.
REQ-015 error  output  1  sticky; a NACK aborted the pass.

Function
REQ-016 Quarter tick SHALL be a counter pulsing once every QUARTER_CYCLES clocks while busy, reloaded to 0 on each pass start; all bus transitions SHALL occur only on ticks.
REQ-017 States SHALL be IDLE, START, BYTE, ACK, STOP, GAP, FINISH.
REQ-018 IDLE -> START when start=1, or on the first cycle after reset release if AUTO_START=1. On entry: busy=1, done=0, error=0, rom_index=0.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 START SHALL last 2 quarters: Q0 SCL and SDA released; Q1 SDA low, SCL released.
REQ-021 Each entry SHALL be one write transaction: START, byte {DEV_ADDR,1'b0}, ACK, byte reg_addr, ACK, byte reg_value, ACK, STOP, GAP.
REQ-022 BYTE SHALL send 8 bits MSB first, 4 quarters per bit: Q0 SCL low and SDA set; Q1 SCL released; Q2 SCL released; Q3 SCL low.
REQ-023 ACK SHALL use the same 4-quarter timing with SDA released and sda_in sampled on the Q2 tick; 0 = ACK, 1 = NACK.
REQ-024 On NACK: error=1, then STOP, then FINISH; no further entries are sent.
REQ-025 STOP SHALL last 3 quarters: SCL low/SDA low; SCL released/SDA low; SCL released/SDA released.
REQ-026 GAP SHALL hold both lines released for 4 quarters.
REQ-027 After GAP, rom_index SHALL increment and the FSM SHALL go to START. After GAP with rom_index == NUM_REGS-1, the FSM SHALL go to FINISH.
REQ-028 FINISH SHALL last one cycle: busy=0, done = ~error; then IDLE with lines released.
REQ-029 rom_data SHALL be latched into a 16-bit register on entry to START and SHALL be stable for the whole transaction.
REQ-030 One transaction SHALL take exactly 117 quarters (2+108+3+4).
REQ-031 The index counter SHALL NOT wrap when NUM_REGS=256; termination uses the compare of REQ-027.

Reset
REQ-032 While nreset_in=0 SHALL hold: scl_oe=0, sda_oe=0, busy=0, done=0, error=0, rom_index=0, FSM=IDLE, tick counter=0.
REQ-033 Reset asserted mid-transaction SHALL immediately release both lines without generating STOP. After release, behaviour SHALL follow REQ-018.

Verification
REQ-034 QUARTER_CYCLES=2, NUM_REGS=2, AUTO_START=1, slave model ACKs all, table {16'h0300,16'h0F80}, release reset -> bytes C0 03 00 then C0 0F 80 decoded; done=1 and busy=0 exactly 468 cycles after the first START tick.
REQ-035 Same setup, slave NACKs the reg_addr byte of entry 0 -> STOP seen; error=1, done=0, rom_index=0; no second START.
REQ-036 AUTO_START=0, pulse start, then pulse start again 50 cycles later -> exactly one pass (2 transactions); the second pulse has no effect.
REQ-037 Assert nreset_in during bit 5 of a data byte -> scl_oe=0 and sda_oe=0 within the same cycle (asynchronous); all outputs at reset values; a new pass begins after release.
REQ-038 Bus monitor for every pass -> SDA never changes while SCL is released, except at START (1->0) and STOP (0->1) edges.
REQ-039 After done, pulse start -> done clears on the next cycle, the pass repeats, and done=1 again.
